// File: rtl/sync_updown_mod_counter.sv
// rtl/sync_updown_mod_counter.sv - up/down modulo-MOD counter with clear, clamped load and wrap pulse
module sync_updown_mod_counter #(
  parameter int WIDTH     = 3,
  parameter int MOD       = 8,
  parameter int RESET_VAL = MOD - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             at_term,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RESET_Q   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             at_max;
  logic             at_min;

  assign at_max  = (q == MAX_VAL);
  assign at_min  = (q == ZERO);
  assign at_term = up_dn ? at_max : at_min;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (clr) begin
      q_next = ZERO;
    end else if (load) begin
      // Out-of-range load values clamp to the top of the count range.
      q_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (!at_max) begin
          q_next = q + ONE;
        end else if (!SATURATE) begin
          q_next    = ZERO;
          wrap_next = 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_next = q - ONE;
        end else if (!SATURATE) begin
          q_next    = MAX_VAL;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// tb/tb_sync_updown_mod_counter.sv - directed checks on three counter configurations
module tb_sync_updown_mod_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // a: defaults (WIDTH=3, MOD=8, RESET_VAL=7, wrapping)
  logic       a_clr, a_load, a_en, a_up_dn, a_at_term, a_wrap;
  logic [2:0] a_load_val, a_q;
  // b: WIDTH=4, MOD=10, RESET_VAL=0
  logic       b_clr, b_load, b_en, b_up_dn, b_at_term, b_wrap;
  logic [3:0] b_load_val, b_q;
  // c: saturating, MOD=8
  logic       c_clr, c_load, c_en, c_up_dn, c_at_term, c_wrap;
  logic [2:0] c_load_val, c_q;

  sync_updown_mod_counter dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up_dn(a_up_dn), .q(a_q), .at_term(a_at_term), .wrap(a_wrap)
  );

  sync_updown_mod_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up_dn(b_up_dn), .q(b_q), .at_term(b_at_term), .wrap(b_wrap)
  );

  sync_updown_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_val(c_load_val),
    .en(c_en), .up_dn(c_up_dn), .q(c_q), .at_term(c_at_term), .wrap(c_wrap)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    a_clr = 0; a_load = 0; a_load_val = 0; a_en = 0; a_up_dn = 0;
    b_clr = 0; b_load = 0; b_load_val = 0; b_en = 0; b_up_dn = 0;
    c_clr = 0; c_load = 0; c_load_val = 0; c_en = 0; c_up_dn = 0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (a_q !== 3'd7) begin bad++; $display("FAIL reset_a_q got=%0d exp=7", a_q); end
    total++; if (a_wrap !== 1'b0) begin bad++; $display("FAIL reset_a_wrap got=%0b exp=0", a_wrap); end
    total++; if (a_at_term !== 1'b0) begin bad++; $display("FAIL reset_a_at_term got=%0b exp=0", a_at_term); end
    total++; if (b_q !== 4'd0) begin bad++; $display("FAIL reset_b_q got=%0d exp=0", b_q); end
    total++; if (b_at_term !== 1'b1) begin bad++; $display("FAIL reset_b_at_term got=%0b exp=1", b_at_term); end
    a_en = 1; a_load = 1; a_load_val = 3'd2; b_en = 1; b_up_dn = 1;
    tick();
    total++; if (a_q !== 3'd7) begin bad++; $display("FAIL reset_ignores_ctrl_a got=%0d exp=7", a_q); end
    total++; if (b_q !== 4'd0) begin bad++; $display("FAIL reset_ignores_ctrl_b got=%0d exp=0", b_q); end
    a_en = 0; a_load = 0; b_en = 0; b_up_dn = 0;
    rst_n = 1'b1;
    tick();
    total++; if (a_q !== 3'd7) begin bad++; $display("FAIL post_reset_hold got=%0d exp=7", a_q); end
  endtask

  task automatic test_down_wrap;
    logic [2:0] exp_q [10] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    a_en = 1; a_up_dn = 0;
    for (int i = 0; i < 10; i++) begin
      total++; if (a_q !== exp_q[i]) begin bad++; $display("FAIL down_q[%0d] got=%0d exp=%0d", i, a_q, exp_q[i]); end
      total++; if (a_wrap !== (i == 8)) begin bad++; $display("FAIL down_wrap[%0d] got=%0b exp=%0b", i, a_wrap, (i == 8)); end
      total++; if (a_at_term !== (exp_q[i] == 3'd0)) begin bad++; $display("FAIL down_at_term[%0d] got=%0b", i, a_at_term); end
      tick();
    end
    a_en = 0;
  endtask

  task automatic test_mod10_up;
    logic [3:0] exp_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    b_en = 1; b_up_dn = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++; if (b_q !== exp_q[i]) begin bad++; $display("FAIL mod10_q[%0d] got=%0d exp=%0d", i, b_q, exp_q[i]); end
      total++; if (b_wrap !== (i == 9)) begin bad++; $display("FAIL mod10_wrap[%0d] got=%0b exp=%0b", i, b_wrap, (i == 9)); end
      total++; if (b_at_term !== (exp_q[i] == 4'd9)) begin bad++; $display("FAIL mod10_at_term[%0d] got=%0b", i, b_at_term); end
    end
    b_en = 0;
  endtask

  task automatic test_load_clamp;
    b_load = 1; b_load_val = 4'd13;
    tick();
    total++; if (b_q !== 4'd9) begin bad++; $display("FAIL load_clamp13 got=%0d exp=9", b_q); end
    total++; if (b_at_term !== 1'b1) begin bad++; $display("FAIL load_at_term got=%0b exp=1", b_at_term); end
    b_clr = 1;
    tick();
    total++; if (b_q !== 4'd0) begin bad++; $display("FAIL clr_over_load got=%0d exp=0", b_q); end
    b_clr = 0; b_load_val = 4'd10; b_en = 1;
    tick();
    total++; if (b_q !== 4'd9) begin bad++; $display("FAIL load_clamp10 got=%0d exp=9", b_q); end
    total++; if (b_wrap !== 1'b0) begin bad++; $display("FAIL load_no_wrap got=%0b exp=0", b_wrap); end
    b_load_val = 4'd4;
    tick();
    total++; if (b_q !== 4'd4) begin bad++; $display("FAIL load_in_range got=%0d exp=4", b_q); end
    b_load = 0; b_en = 0;
  endtask

  task automatic test_saturate;
    c_clr = 1;
    tick();
    total++; if (c_q !== 3'd0) begin bad++; $display("FAIL sat_clr got=%0d exp=0", c_q); end
    c_clr = 0; c_up_dn = 0; c_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (c_q !== 3'd0) begin bad++; $display("FAIL sat_low_q[%0d] got=%0d exp=0", i, c_q); end
      total++; if (c_wrap !== 1'b0) begin bad++; $display("FAIL sat_low_wrap[%0d] got=%0b exp=0", i, c_wrap); end
      total++; if (c_at_term !== 1'b1) begin bad++; $display("FAIL sat_low_at_term[%0d] got=%0b exp=1", i, c_at_term); end
    end
    c_up_dn = 1;
    tick();
    total++; if (c_q !== 3'd1) begin bad++; $display("FAIL sat_turn_up got=%0d exp=1", c_q); end
    c_en = 0; c_load = 1; c_load_val = 3'd7;
    tick();
    c_load = 0; c_en = 1;
    tick();
    total++; if (c_q !== 3'd7) begin bad++; $display("FAIL sat_high_q got=%0d exp=7", c_q); end
    total++; if (c_wrap !== 1'b0) begin bad++; $display("FAIL sat_high_wrap got=%0b exp=0", c_wrap); end
    total++; if (c_at_term !== 1'b1) begin bad++; $display("FAIL sat_high_at_term got=%0b exp=1", c_at_term); end
    c_en = 0;
  endtask

  task automatic test_async_reset;
    a_load = 1; a_load_val = 3'd5;
    tick();
    total++; if (a_q !== 3'd5) begin bad++; $display("FAIL ar_load5 got=%0d exp=5", a_q); end
    a_load = 0; a_en = 1; a_up_dn = 1;
    tick();
    total++; if (a_q !== 3'd6) begin bad++; $display("FAIL ar_count got=%0d exp=6", a_q); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_q !== 3'd7) begin bad++; $display("FAIL ar_async_q got=%0d exp=7", a_q); end
    total++; if (a_wrap !== 1'b0) begin bad++; $display("FAIL ar_async_wrap got=%0b exp=0", a_wrap); end
    total++; if (a_at_term !== 1'b1) begin bad++; $display("FAIL ar_at_term_in_reset got=%0b exp=1", a_at_term); end
    rst_n = 1'b1; a_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (a_q !== 3'd7) begin bad++; $display("FAIL ar_hold[%0d] got=%0d exp=7", i, a_q); end
    end
    a_en = 1;
    tick();
    total++; if (a_q !== 3'd0) begin bad++; $display("FAIL ar_wrap_q got=%0d exp=0", a_q); end
    total++; if (a_wrap !== 1'b1) begin bad++; $display("FAIL ar_wrap_set got=%0b exp=1", a_wrap); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_wrap !== 1'b0) begin bad++; $display("FAIL ar_wrap_cleared got=%0b exp=0", a_wrap); end
    total++; if (a_q !== 3'd7) begin bad++; $display("FAIL ar_second_q got=%0d exp=7", a_q); end
    rst_n = 1'b1; a_en = 0;
  endtask

  task automatic test_back_to_back;
    a_en = 1; a_up_dn = 0;
    tick();
    total++; if (a_q !== 3'd6) begin bad++; $display("FAIL b2b_down got=%0d exp=6", a_q); end
    a_up_dn = 1;
    tick();
    total++; if (a_q !== 3'd7) begin bad++; $display("FAIL b2b_up got=%0d exp=7", a_q); end
    total++; if (a_at_term !== 1'b1) begin bad++; $display("FAIL b2b_at_term_up got=%0b exp=1", a_at_term); end
    tick();
    total++; if (a_q !== 3'd0 || a_wrap !== 1'b1) begin bad++; $display("FAIL b2b_wrap_up got=%0d/%0b exp=0/1", a_q, a_wrap); end
    a_up_dn = 0;
    tick();
    total++; if (a_q !== 3'd7 || a_wrap !== 1'b1) begin bad++; $display("FAIL b2b_wrap_down got=%0d/%0b exp=7/1", a_q, a_wrap); end
    total++; if (a_at_term !== 1'b0) begin bad++; $display("FAIL b2b_at_term_down got=%0b exp=0", a_at_term); end
    tick();
    total++; if (a_q !== 3'd6 || a_wrap !== 1'b0) begin bad++; $display("FAIL b2b_after got=%0d/%0b exp=6/0", a_q, a_wrap); end
    a_en = 0;
    tick();
    total++; if (a_q !== 3'd6 || a_wrap !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0d/%0b exp=6/0", a_q, a_wrap); end
  endtask

  initial begin
    test_reset();
    test_down_wrap();
    test_mod10_up();
    test_load_clamp();
    test_saturate();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
